// File: rtl/roz_pixel_fetch_fifo.sv
// roz_pixel_fetch_fifo: ROZ tile pixel fetch engine with a one-word ROM cache.
// Ports: clk/reset_n/flush; wr/code/pixel_x/pixel_y/in_full push side;
// rd/color/out_empty/out_count pop side; overflow/underflow sticky flags;
// rom_address/rom_req/rom_data/rom_ack toggle-handshake ROM port.
module roz_pixel_fetch_fifo #(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned BPP = 4,
  parameter int unsigned CODE_BITS = 14,
  parameter int unsigned CHI_BITS = 2,
  parameter logic [26:0] ROM_BASE = 27'h0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic                          wr,
  input  logic [CODE_BITS+CHI_BITS-1:0] code,
  input  logic [2:0]                    pixel_x,
  input  logic [2:0]                    pixel_y,
  output logic                          in_full,
  input  logic                          rd,
  output logic [CHI_BITS+BPP-1:0]       color,
  output logic                          out_empty,
  output logic [DEPTH_LOG2:0]           out_count,
  output logic                          overflow,
  output logic                          underflow,
  output logic [26:0]                   rom_address,
  output logic                          rom_req,
  input  logic [15:0]                   rom_data,
  input  logic                          rom_ack
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned KW = CODE_BITS + CHI_BITS;
  localparam int unsigned IW = KW + 6;
  localparam int unsigned CW = CHI_BITS + BPP;

  typedef logic [DEPTH_LOG2:0] ptr_t;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Select the pixel field from a fetched ROM word.
  // 4bpp pixels are nibble-swapped within each byte.
  function automatic logic [BPP-1:0] pick(
    input logic [15:0] w,
    input logic [1:0]  s
  );
    logic [7:0] f;
    if (BPP == 8) begin
      f = s[0] ? w[15:8] : w[7:0];
    end else begin
      unique case (s)
        2'd0: f = {4'h0, w[7:4]};
        2'd1: f = {4'h0, w[3:0]};
        2'd2: f = {4'h0, w[15:12]};
        default: f = {4'h0, w[11:8]};
      endcase
    end
    return f[BPP-1:0];
  endfunction

  // ---------------- input FIFO ----------------
  logic [IW-1:0] in_mem [DEPTH];
  ptr_t          in_wp;
  ptr_t          in_rp;
  logic          in_empty;
  logic          push;
  logic          issue;

  assign in_empty = in_wp == in_rp;
  assign in_full  = (in_wp[DEPTH_LOG2] != in_rp[DEPTH_LOG2]) &&
                    (in_wp[DEPTH_LOG2-1:0] == in_rp[DEPTH_LOG2-1:0]);
  assign push     = wr && !in_full && !flush;

  always_ff @(posedge clk) begin
    if (push) begin
      in_mem[in_wp[DEPTH_LOG2-1:0]] <= {code, pixel_x, pixel_y};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_wp <= '0;
      in_rp <= '0;
    end else if (flush) begin
      in_wp <= '0;
      in_rp <= '0;
    end else begin
      if (push)  in_wp <= in_wp + 1'b1;
      if (issue) in_rp <= in_rp + 1'b1;
    end
  end

  // ---------------- head decode ----------------
  logic [IW-1:0]        head;
  logic [CHI_BITS-1:0]  h_chi;
  logic [CODE_BITS-1:0] h_idx;
  logic [2:0]           h_px;
  logic [2:0]           h_py;
  logic [26:0]          h_addr;
  logic [1:0]           h_sel;

  assign head = in_mem[in_rp[DEPTH_LOG2-1:0]];
  assign {h_chi, h_idx, h_px, h_py} = head;

  always_comb begin
    h_addr = '0;
    h_sel  = '0;
    if (BPP == 8) begin
      h_addr = ROM_BASE + 27'({h_idx, h_py, h_px[2:1], 1'b0});
      h_sel  = {1'b0, h_px[0]};
    end else begin
      h_addr = ROM_BASE + 27'({h_idx, h_py, h_px[2], 1'b0});
      h_sel  = h_px[1:0];
    end
  end

  // ---------------- output FIFO ----------------
  logic [CW-1:0] out_mem [DEPTH];
  ptr_t          out_wp;
  ptr_t          out_rp;
  logic          out_full;
  logic          out_we;
  logic [CW-1:0] out_wdata;
  logic          pop;

  assign out_count = out_wp - out_rp;
  assign out_empty = out_wp == out_rp;
  // count never exceeds DEPTH, so its MSB alone marks full
  assign out_full  = out_count[DEPTH_LOG2];
  assign pop       = rd && !out_empty && !flush;
  assign color     = out_empty ? '0 :
                     out_mem[out_rp[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (out_we) begin
      out_mem[out_wp[DEPTH_LOG2-1:0]] <= out_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_wp <= '0;
      out_rp <= '0;
    end else if (flush) begin
      out_wp <= '0;
      out_rp <= '0;
    end else begin
      if (out_we) out_wp <= out_wp + 1'b1;
      if (pop)    out_rp <= out_rp + 1'b1;
    end
  end

  // ---------------- sticky flags ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && in_full && !flush)   overflow  <= 1'b1;
      if (rd && out_empty && !flush) underflow <= 1'b1;
    end
  end

  // ---------------- fetch engine ----------------
  state_t              state;
  state_t              state_nx;
  logic                cache_v;
  logic [26:0]         cache_a;
  logic [15:0]         cache_d;
  logic [CHI_BITS-1:0] m_chi;
  logic [1:0]          m_sel;
  logic                ack_eq;
  logic                zero;
  logic                hit;
  logic                miss;
  logic                fill;

  assign ack_eq = rom_ack == rom_req;
  assign zero   = h_idx == '0;
  assign hit    = cache_v && (cache_a == h_addr);
  // in IDLE nothing is in flight, so a free output slot is enough
  assign issue  = (state == S_IDLE) && !flush &&
                  !in_empty && !out_full;
  assign miss   = issue && !zero && !hit;
  assign fill   = (state == S_WAIT) && ack_eq && !flush;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (miss) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (ack_eq)     state_nx = S_IDLE;
        else if (flush) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (ack_eq) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    out_we    = 1'b0;
    out_wdata = '0;
    if (fill) begin
      out_we    = 1'b1;
      out_wdata = {m_chi, pick(rom_data, m_sel)};
    end else if (issue && zero) begin
      out_we    = 1'b1;
      out_wdata = '0;
    end else if (issue && hit) begin
      out_we    = 1'b1;
      out_wdata = {h_chi, pick(cache_d, h_sel)};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rom_req     <= 1'b0;
      rom_address <= '0;
      m_chi       <= '0;
      m_sel       <= '0;
    end else if (miss) begin
      rom_req     <= ~rom_req;
      rom_address <= h_addr;
      m_chi       <= h_chi;
      m_sel       <= h_sel;
    end
  end

  // a word returning in DRAIN never reaches here: fill needs WAIT
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cache_v <= 1'b0;
      cache_a <= '0;
      cache_d <= '0;
    end else if (flush) begin
      cache_v <= 1'b0;
    end else if (fill) begin
      cache_v <= 1'b1;
      cache_a <= rom_address;
      cache_d <= rom_data;
    end
  end

endmodule

// File: tb/tb_roz_pixel_fetch_fifo.sv
// tb_roz_pixel_fetch_fifo: directed + random bench for roz_pixel_fetch_fifo.
// Drives a 4bpp and an 8bpp instance against toggle-handshake ROM models.
module tb_roz_pixel_fetch_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        wr;
  logic        rd;
  logic        wr8;
  logic        rd8;
  logic [15:0] code;
  logic [2:0]  px;
  logic [2:0]  py;

  logic        in_full4, out_empty4, ovf4, udf4, req4;
  logic        ack4 = 1'b0;
  logic [5:0]  color4;
  logic [9:0]  out_count4;
  logic [26:0] addr4;
  logic [15:0] data4 = 16'h0;

  logic        in_full8, out_empty8, ovf8, udf8, req8;
  logic        ack8 = 1'b0;
  logic [9:0]  color8;
  logic [3:0]  out_count8;
  logic [26:0] addr8;
  logic [15:0] data8 = 16'h0;

  int checks = 0;
  int passes = 0;
  int tog4 = 0;
  int tog8 = 0;
  int lat4 = 2;
  int cnt4 = 0;
  int cnt8 = 0;
  bit use_force = 1'b0;
  logic [15:0] force_d = 16'h0;

  always #5 clk = ~clk;

  roz_pixel_fetch_fifo #(
    .DEPTH_LOG2(9), .BPP(4), .CODE_BITS(14),
    .CHI_BITS(2), .ROM_BASE(27'h0)
  ) u4 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .wr(wr), .code(code), .pixel_x(px), .pixel_y(py),
    .in_full(in_full4), .rd(rd), .color(color4),
    .out_empty(out_empty4), .out_count(out_count4),
    .overflow(ovf4), .underflow(udf4),
    .rom_address(addr4), .rom_req(req4),
    .rom_data(data4), .rom_ack(ack4)
  );

  roz_pixel_fetch_fifo #(
    .DEPTH_LOG2(3), .BPP(8), .CODE_BITS(14),
    .CHI_BITS(2), .ROM_BASE(27'h100)
  ) u8 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .wr(wr8), .code(code), .pixel_x(px), .pixel_y(py),
    .in_full(in_full8), .rd(rd8), .color(color8),
    .out_empty(out_empty8), .out_count(out_count8),
    .overflow(ovf8), .underflow(udf8),
    .rom_address(addr8), .rom_req(req8),
    .rom_data(data8), .rom_ack(ack8)
  );

  // ROM contents: a fixed scramble of the byte address
  function automatic logic [15:0] romfn(logic [26:0] a);
    return (a[15:0] * 16'h9E37) ^ {5'b0, a[26:16]} ^ 16'h1234;
  endfunction

  // expected 4bpp colour from the pixel rules
  function automatic logic [31:0] exp4(
    logic [15:0] c, logic [2:0] x, logic [2:0] y);
    int idx = int'(c) % 16384;
    int chi = int'(c) / 16384;
    int lsb [4] = '{4, 0, 12, 8};
    logic [26:0] a;
    logic [15:0] w;
    if (idx == 0) return 32'h0;
    a = 27'(idx * 32 + int'(y) * 4 + (int'(x) / 4) * 2);
    w = romfn(a);
    return 32'(chi * 16 + ((int'(w) >> lsb[int'(x) % 4]) % 16));
  endfunction

  function automatic logic [31:0] rom8(
    logic [15:0] c, logic [2:0] x, logic [2:0] y);
    int idx = int'(c) % 16384;
    return 32'(256 + idx * 64 + int'(y) * 8 + (int'(x) / 2) * 2);
  endfunction

  function automatic logic [31:0] exp8(
    logic [15:0] c, logic [2:0] x, logic [2:0] y);
    int chi = int'(c) / 16384;
    logic [15:0] w;
    if (int'(c) % 16384 == 0) return 32'h0;
    w = romfn(27'(rom8(c, x, y)));
    return 32'(chi * 256 + ((int'(w) >> (8 * (int'(x) % 2))) % 256));
  endfunction

  always @(req4) tog4++;
  always @(req8) tog8++;

  always @(posedge clk) begin
    if (reset_n && req4 !== ack4) begin
      if (cnt4 >= lat4) begin
        data4 <= use_force ? force_d : romfn(addr4);
        ack4  <= req4;
        cnt4  <= 0;
      end else begin
        cnt4 <= cnt4 + 1;
      end
    end else begin
      cnt4 <= 0;
    end
  end

  always @(posedge clk) begin
    if (reset_n && req8 !== ack8) begin
      if (cnt8 >= 1) begin
        data8 <= romfn(addr8);
        ack8  <= req8;
        cnt8  <= 0;
      end else begin
        cnt8 <= cnt8 + 1;
      end
    end else begin
      cnt8 <= 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic push4(logic [15:0] c, logic [2:0] x, logic [2:0] y);
    code = c; px = x; py = y; wr = 1'b1;
    step();
    wr = 1'b0;
  endtask

  task automatic wait_ne(bit sel8, int n);
    for (int i = 0; i < n; i++) begin
      if (sel8 ? !out_empty8 : !out_empty4) break;
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int acc;
    int pushed;
    logic [15:0] c;
    logic [2:0] x;
    logic [2:0] y;
    logic [31:0] e;
    logic [5:0] nib_x [8];
    reset_n = 1'b0; flush = 1'b1;
    wr = 1'b0; rd = 1'b1; wr8 = 1'b0; rd8 = 1'b0;
    code = '0; px = '0; py = '0;
    step(); step();
    flush = 1'b0; rd = 1'b0;
    step();

    // reset state
    chk("rst_empty", out_empty4, 1);
    chk("rst_full", in_full4, 0);
    chk("rst_count", out_count4, 0);
    chk("rst_color", color4, 0);
    chk("rst_req", req4, 0);
    chk("rst_addr", addr4, 0);
    chk("rst_ovf", ovf4, 0);
    chk("rst_udf", udf4, 0);
    reset_n = 1'b1;
    step();

    // single miss with a forced ROM word
    use_force = 1'b1; force_d = 16'hABCD; lat4 = 3;
    t0 = tog4;
    push4(16'h4001, 3'd1, 3'd2);
    step();
    chk("miss_toggle", tog4 - t0, 1);
    chk("miss_addr", addr4, 27'h28);
    wait_ne(1'b0, 40);
    chk("miss_ready", out_empty4, 0);
    chk("miss_color", color4, 6'h1D);
    rd = 1'b1; step(); rd = 1'b0;
    chk("miss_popped", out_count4, 0);
    use_force = 1'b0;

    // 8bpp instance: miss then hit in the same word
    t0 = tog8;
    code = 16'h0003; px = 3'd5; py = 3'd7; wr8 = 1'b1;
    step(); wr8 = 1'b0; step();
    chk("b8_addr", addr8, rom8(16'h0003, 3'd5, 3'd7));
    wait_ne(1'b1, 40);
    chk("b8_color", color8, exp8(16'h0003, 3'd5, 3'd7));
    rd8 = 1'b1;
    code = 16'hC003; px = 3'd4; wr8 = 1'b1;
    step(); rd8 = 1'b0; wr8 = 1'b0;
    wait_ne(1'b1, 10);
    chk("b8_hit_color", color8, exp8(16'hC003, 3'd4, 3'd7));
    chk("b8_one_toggle", tog8 - t0, 1);
    rd8 = 1'b1; step(); rd8 = 1'b0;

    // eight pixels of one tile row: one fetch, then a pixel per clock
    lat4 = 2; t0 = tog4;
    for (int i = 0; i < 8; i++) begin
      code = 16'h8005; px = 3'(i % 4); py = 3'd3; wr = 1'b1;
      nib_x[i] = 6'(exp4(16'h8005, 3'(i % 4), 3'd3));
      step();
    end
    wr = 1'b0;
    wait_ne(1'b0, 60);
    chk("row_first", out_empty4, 0);
    for (int i = 0; i < 7; i++) step();
    chk("row_count", out_count4, 8);
    chk("row_toggles", tog4 - t0, 1);
    for (int i = 0; i < 8; i++) begin
      chk("row_color", color4, 32'(nib_x[i]));
      rd = 1'b1; step();
    end
    rd = 1'b0;
    chk("row_drained", out_empty4, 1);

    // random traffic against an ordered colour queue
    begin
      logic [31:0] q [$];
      pushed = 0;
      for (int cyc = 0; cyc < 3000 &&
           (pushed < 200 || q.size() != 0); cyc++) begin
        wr = 1'b0; rd = 1'b0;
        if (cyc % 40 == 0) lat4 = $urandom_range(0, 5);
        if (pushed < 200 && $urandom_range(0, 1) == 1) begin
          t0 = $urandom_range(0, 3);
          c = 16'(($urandom_range(0, 3) << 14) |
                  (t0 == 0 ? 0 : t0 + 1));
          x = 3'($urandom_range(0, 7));
          y = 3'($urandom_range(0, 7));
          code = c; px = x; py = y; wr = 1'b1;
          q.push_back(exp4(c, x, y));
          pushed++;
        end
        if (out_count4 != 0 && $urandom_range(0, 2) != 0) begin
          e = (q.size() != 0) ? q.pop_front() : 32'hFFFF_FFFF;
          chk("rand_pop", color4, e);
          rd = 1'b1;
        end
        step();
      end
      wr = 1'b0; rd = 1'b0;
      chk("rand_left", q.size(), 0);
      chk("rand_count", out_count4, 0);
      chk("rand_ovf", ovf4, 0);
      chk("rand_udf", udf4, 0);
    end

    // zero-index fill until both FIFOs are full
    lat4 = 2;
    code = 16'h0; px = '0; py = '0;
    acc = 0;
    for (int i = 0; i < 1100 && !in_full4; i++) begin
      wr = 1'b1; step(); acc++;
    end
    wr = 1'b0;
    chk("fill_accepted", acc, 1024);
    chk("fill_in_full", in_full4, 1);
    chk("fill_out_count", out_count4, 512);
    chk("fill_color", color4, 0);
    chk("fill_no_ovf", ovf4, 0);
    push4(16'h0, 3'd0, 3'd0);
    chk("fill_ovf", ovf4, 1);
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_count", out_count4, 0);
    chk("flush_empty", out_empty4, 1);
    chk("flush_in_full", in_full4, 0);
    chk("flush_ovf_kept", ovf4, 1);

    // flush while a fetch is outstanding
    lat4 = 10; t0 = tog4;
    push4(16'h0007, 3'd0, 3'd0);
    step(); step(); step();
    flush = 1'b1; step(); flush = 1'b0;
    push4(16'h0007, 3'd0, 3'd0);
    step(); step(); step();
    chk("drain_no_req", tog4 - t0, 1);
    chk("drain_empty", out_empty4, 1);
    wait_ne(1'b0, 60);
    chk("drain_refetch", tog4 - t0, 2);
    chk("drain_count", out_count4, 1);
    chk("drain_color", color4, exp4(16'h0007, 3'd0, 3'd0));
    rd = 1'b1; step(); rd = 1'b0;

    // pop while empty
    chk("udf_before", udf4, 0);
    rd = 1'b1; step(); rd = 1'b0;
    chk("udf_set", udf4, 1);
    chk("udf_color", color4, 0);
    chk("udf_count", out_count4, 0);
    step();
    chk("udf_sticky", udf4, 1);
    reset_n = 1'b0; step(); reset_n = 1'b1; step();
    chk("rst2_udf", udf4, 0);
    chk("rst2_ovf", ovf4, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
